// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: sequential fetch engine with a circular FWFT queue
// feeding issue, plus branch redirect that flushes the queue and discards any
// response still in flight for the old path.
module if_fetch_queue #(
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = 32,
  parameter int INSTR_W     = 32,
  parameter int INSTR_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       redirect_en_in,
  input  logic [ADDR_W-1:0]          redirect_pc_in,
  output logic                       mem_req_out,
  output logic [ADDR_W-1:0]          mem_addr_out,
  output logic [2:0]                 mem_len_out,
  input  logic                       mem_gnt_in,
  input  logic                       mem_rsp_en_in,
  input  logic [INSTR_W-1:0]         mem_rsp_data_in,
  output logic                       issue_valid_out,
  output logic [INSTR_W-1:0]         issue_instr_out,
  output logic [ADDR_W-1:0]          issue_pc_out,
  input  logic                       issue_ready_in,
  output logic [$clog2(DEPTH):0]     count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // DROP means a response is still owed by the allocator but belongs to a
  // path that was abandoned by a redirect, so it must be swallowed.
  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDrop
  } fetchState_e;

  fetchState_e       state_q, state_d;
  logic [ADDR_W-1:0] fetchPc_q, fetchPc_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [INSTR_W-1:0] instrMem [DEPTH];
  logic [ADDR_W-1:0]  pcMem    [DEPTH];

  logic push;
  logic pop;
  logic issueValid;

  assign issueValid = (count_q != '0);

  // A redirect cancels both the push and the pop of its cycle.
  assign push = rdy_in && !redirect_en_in && (state_q == StWait) && mem_rsp_en_in;
  assign pop  = rdy_in && !redirect_en_in && issueValid && issue_ready_in;

  assign mem_req_out     = (state_q == StReq);
  assign mem_addr_out    = fetchPc_q;
  assign mem_len_out     = 3'(INSTR_BYTES - 1);
  assign issue_valid_out = issueValid;
  assign issue_instr_out = instrMem[head_q];
  assign issue_pc_out    = pcMem[head_q];
  assign count_out       = count_q;

  // Next-state logic for the fetch FSM, fetch PC and queue pointers.
  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    if (rdy_in) begin
      if (redirect_en_in) begin
        head_d    = '0;
        tail_d    = '0;
        count_d   = '0;
        fetchPc_d = redirect_pc_in;
        unique case (state_q)
          StIdle: state_d = StIdle;
          StReq:  state_d = mem_gnt_in    ? StDrop : StIdle;
          StWait: state_d = mem_rsp_en_in ? StIdle : StDrop;
          StDrop: state_d = mem_rsp_en_in ? StIdle : StDrop;
          default: state_d = StIdle;
        endcase
      end else begin
        unique case (state_q)
          StIdle: begin
            if (count_q < CNT_W'(DEPTH)) begin
              state_d = StReq;
            end
          end
          StReq: begin
            if (mem_gnt_in) begin
              state_d = StWait;
            end
          end
          StWait: begin
            if (mem_rsp_en_in) begin
              state_d   = StIdle;
              fetchPc_d = fetchPc_q + ADDR_W'(INSTR_BYTES);
            end
          end
          StDrop: begin
            if (mem_rsp_en_in) begin
              state_d = StIdle;
            end
          end
          default: state_d = StIdle;
        endcase

        if (push) begin
          tail_d = tail_q + PTR_W'(1);
        end
        if (pop) begin
          head_d = head_q + PTR_W'(1);
        end
        if (push && !pop) begin
          count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
          count_d = count_q - CNT_W'(1);
        end
      end
    end
  end

  // Control registers; rdy_in low is handled by next-state equal to current.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= StIdle;
      fetchPc_q <= RESET_PC;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      fetchPc_q <= fetchPc_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Queue storage is never reset; count gates whether the head is meaningful.
  always_ff @(posedge clk_in) begin
    if (push) begin
      instrMem[tail_q] <= mem_rsp_data_in;
      pcMem[tail_q]    <= fetchPc_q;
    end
  end

endmodule
